fp_div_ctrl: RTL and testbench

- Sequential control/issue stage directly upstream of the combinational single-precision FP divider (`div_fp_single`).
- Accepts operand pairs over a valid/ready handshake and classifies them.
- Special cases (zero/inf/NaN/denormal) and exponent over/underflow are resolved locally.
- Normal operands go to the divider, which gets a fixed DIV_LAT-cycle multicycle window. The registered result and IEEE flags are presented downstream over a valid/ready handshake.

---
 rtl/fp_div_pkg.sv | 20 ++
 rtl/fp_classify.sv | 21 ++
 rtl/fp_div_ctrl.sv | 129 ++++++++++++
 tb/tb_fp_div_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the single-precision divider issue stage.
package fp_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [9:0]  EXP_BIAS = 10'd127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;

  // Bit positions inside the {nv, dz, of, uf} flag vector.
  localparam int FLG_NV = 3;
  localparam int FLG_DZ = 2;
  localparam int FLG_OF = 1;
  localparam int FLG_UF = 0;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single classifier; denormals are flushed and reported as zero.
module fp_classify (
  input  logic [31:0] op,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan,
  output logic        is_denorm
);
  import fp_div_pkg::*;

  logic [7:0] exp_f;
  logic       frac_nz;

  assign exp_f     = op[30:23];
  assign frac_nz   = |op[22:0];
  assign is_denorm = (exp_f == 8'd0) && frac_nz;
  assign is_zero   = (exp_f == 8'd0);
  assign is_inf    = (exp_f == EXP_MAX) && !frac_nz;
  assign is_nan    = (exp_f == EXP_MAX) && frac_nz;

endmodule

// File: rtl/fp_div_ctrl.sv
// Issue/control stage in front of a combinational FP divider: resolves special
// operands locally and gives normal operands a fixed multicycle window.
module fp_div_ctrl #(
  parameter int DIV_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
);
  import fp_div_pkg::*;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] div_a_q, div_a_d, div_b_q, div_b_d;
  logic [31:0] res_q, res_d;
  logic [3:0]  flags_q, flags_d;

  logic a_zero_raw, a_inf, a_nan, a_denorm;
  logic b_zero_raw, b_inf, b_nan, b_denorm;
  logic a_zero, b_zero;

  fp_classify u_cls_a (
    .op(in_a), .is_zero(a_zero_raw), .is_inf(a_inf), .is_nan(a_nan), .is_denorm(a_denorm)
  );
  fp_classify u_cls_b (
    .op(in_b), .is_zero(b_zero_raw), .is_inf(b_inf), .is_nan(b_nan), .is_denorm(b_denorm)
  );

  assign a_zero = a_zero_raw | a_denorm;
  assign b_zero = b_zero_raw | b_denorm;

  logic       so;
  logic [9:0] e_wide;
  logic       mant_ge, of_hit, uf_hit;

  assign so      = in_a[31] ^ in_b[31];
  assign e_wide  = {2'b00, in_a[30:23]} - {2'b00, in_b[30:23]} + EXP_BIAS;
  assign mant_ge = (in_a[22:0] >= in_b[22:0]);
  // When ma < mb the quotient significand renormalises down by one exponent step.
  assign of_hit  = ($signed(e_wide) >= 10'sd256) || ((e_wide == 10'd255) && mant_ge);
  assign uf_hit  = ($signed(e_wide) <= 10'sd0)   || ((e_wide == 10'd1) && !mant_ge);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          div_a_d = in_a;
          div_b_d = in_b;
          flags_d = '0;
          state_d = DONE;
          if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            res_d           = QNAN;
            flags_d[FLG_NV] = 1'b1;
          end else if (a_inf) begin
            res_d = {so, EXP_MAX, 23'd0};
          end else if (b_zero) begin
            res_d           = {so, EXP_MAX, 23'd0};
            flags_d[FLG_DZ] = 1'b1;
          end else if (a_zero || b_inf) begin
            res_d = {so, 31'd0};
          end else if (of_hit) begin
            res_d           = {so, EXP_MAX, 23'd0};
            flags_d[FLG_OF] = 1'b1;
          end else if (uf_hit) begin
            res_d           = {so, 31'd0};
            flags_d[FLG_UF] = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(DIV_LAT);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          res_d   = div_res;
          flags_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_a_q <= '0;
      div_b_q <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign out_result = res_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_fp_div_ctrl.sv
// Directed bench for fp_div_ctrl with a behavioural divider stub and result model.
module tb_fp_div_ctrl;

  localparam int DIV_LAT = 2;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [31:0] div_a, div_b, div_res;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int checks = 0;
  int errors = 0;

  fp_div_ctrl #(.DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .div_a(div_a), .div_b(div_b), .div_res(div_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating divide of two normal operands (stands in for div_fp_single).
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] num, den, q;
    int e;
    num = 64'({1'b1, a[22:0]}) << 25;
    den = 64'({1'b1, b[22:0]});
    q   = num / den;
    e   = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q[25]) return {a[31] ^ b[31], 8'(e), q[24:2]};
    else       return {a[31] ^ b[31], 8'(e - 1), q[23:1]};
  endfunction

  assign div_res = ref_div(div_a, div_b);

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] f, output bit sp);
    int ea, eb, e;
    logic [22:0] ma, mb;
    bit so, za, zb, ia, ib, na, nb;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    ma = a[22:0];        mb = b[22:0];
    so = a[31] ^ b[31];
    za = (ea == 0);      zb = (eb == 0);
    ia = (ea == 255) && (ma == 0); ib = (eb == 255) && (mb == 0);
    na = (ea == 255) && (ma != 0); nb = (eb == 255) && (mb != 0);
    e  = ea - eb + 127;
    sp = 1'b1;
    f  = 4'b0000;
    if (na || nb || (za && zb) || (ia && ib)) begin r = 32'h7FC00000; f = 4'b1000; end
    else if (ia)                              r = {so, 8'hFF, 23'd0};
    else if (zb)                        begin r = {so, 8'hFF, 23'd0}; f = 4'b0100; end
    else if (za || ib)                        r = {so, 31'd0};
    else if (e >= 256 || (e == 255 && ma >= mb)) begin r = {so, 8'hFF, 23'd0}; f = 4'b0010; end
    else if (e <= 0 || (e == 1 && ma < mb))      begin r = {so, 31'd0}; f = 4'b0001; end
    else begin sp = 1'b0; r = ref_div(a, b); end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall,
                        input bit has_lit, input logic [31:0] lit_r, input logic [3:0] lit_f);
    logic [31:0] mr;
    logic [3:0]  mf;
    bit          sp;
    int          lat;
    model(a, b, mr, mf, sp);
    lat = sp ? 0 : DIV_LAT;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    for (int k = 0; k < lat; k++) begin
      chk("busy_out_valid", 32'(out_valid), 32'd0);
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    chk("done_out_valid", 32'(out_valid), 32'd1);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("result", out_result, mr);
    chk("flags", 32'(out_flags), 32'(mf));
    chk("div_a", div_a, a);
    chk("div_b", div_b, b);
    if (has_lit) begin
      chk("result_lit", out_result, lit_r);
      chk("flags_lit", 32'(out_flags), 32'(lit_f));
    end
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_result", out_result, mr);
      chk("stall_flags", 32'(out_flags), 32'(mf));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_div_a", div_a, a);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hs_out_valid", 32'(out_valid), 32'd0);
    chk("hs_in_ready", 32'(in_ready), 32'd1);
    $display("op a=%h b=%h stall=%0d -> result=%h flags=%b", a, b, stall, mr, mf);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_div_b", div_b, 32'd0);
    rst = 1'b0;

    run_op(32'h40C00000, 32'h40000000, 0, 1, 32'h40400000, 4'b0000);
    run_op(32'h3F800000, 32'h00000000, 0, 1, 32'h7F800000, 4'b0100);
    run_op(32'h3F800000, 32'h00000001, 0, 1, 32'h7F800000, 4'b0100);
    run_op(32'h00000000, 32'h00000000, 0, 1, 32'h7FC00000, 4'b1000);
    run_op(32'hFF800000, 32'h40000000, 0, 1, 32'hFF800000, 4'b0000);
    run_op(32'h7F000000, 32'h3E800000, 0, 1, 32'h7F800000, 4'b0010);
    run_op(32'h00800000, 32'h7F000000, 0, 1, 32'h00000000, 4'b0001);
    run_op(32'h3F800000, 32'h40400000, 0, 0, 32'h0, 4'b0);
    run_op(32'h7FC00001, 32'h3F800000, 0, 0, 32'h0, 4'b0);
    run_op(32'h7F800000, 32'hFF800000, 0, 0, 32'h0, 4'b0);
    run_op(32'h80000000, 32'hC0A00000, 0, 1, 32'h00000000, 4'b0000);
    run_op(32'h40000000, 32'h7F800000, 0, 0, 32'h0, 4'b0);
    run_op(32'h7F800000, 32'h00000000, 0, 1, 32'h7F800000, 4'b0000);
    run_op(32'h7F000000, 32'h3F400000, 0, 0, 32'h0, 4'b0);
    run_op(32'h7F000000, 32'h3F000000, 0, 1, 32'h7F800000, 4'b0010);
    run_op(32'h00800000, 32'h3F800000, 0, 1, 32'h00800000, 4'b0000);
    run_op(32'h00800000, 32'h3FC00000, 0, 1, 32'h00000000, 4'b0001);
    run_op(32'h40C00000, 32'h40000000, 5, 1, 32'h40400000, 4'b0000);
    run_op(32'h3F800000, 32'h00000000, 3, 1, 32'h7F800000, 4'b0100);

    // Asynchronous reset while the divider window is open.
    @(negedge clk);
    in_a = 32'h40C00000; in_b = 32'h40000000; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_div_a", div_a, 32'd0);
    chk("mid_rst_out_result", out_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("reset asserted mid-operation");
    run_op(32'h40C00000, 32'h40000000, 0, 1, 32'h40400000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
